// File: rtl/dmem_arbiter_if.sv
// Requester-side access port of the data-memory arbiter: request fields in,
// grant and registered read response out.
interface dmem_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, wr, size, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, wr, size, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-addressed data
// memory: grants one requester, checks legality, builds lane enables, returns a
// registered right-aligned response.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_if.slave       r0,
    dmem_arbiter_if.slave       r1,
    output logic [31:0]         m_addr,
    output logic [31:0]         m_wdata,
    output logic [3:0]          m_we,
    input  logic [31:0]         m_rdata
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    // last_q = 1 means port 1 was granted most recently, so port 0 wins next contention
    logic          last_q, last_d;
    logic          gnt0, gnt1, any_gnt;

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_wr;
    logic [1:0]    s_size;
    logic [1:0]    off;
    logic          legal;
    logic [DW-1:0] ld_shift, ld_data;

    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Arbitration: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (r0.req && (!r1.req || last_q)) begin
                gnt0 = 1'b1;
            end else if (r1.req) begin
                gnt1 = 1'b1;
            end
        end
        any_gnt = gnt0 | gnt1;
        last_d  = any_gnt ? gnt1 : last_q;
    end

    // Selected access fields and legality check.
    always_comb begin
        s_addr  = gnt1 ? r1.addr  : r0.addr;
        s_wdata = gnt1 ? r1.wdata : r0.wdata;
        s_wr    = gnt1 ? r1.wr    : r0.wr;
        s_size  = gnt1 ? r1.size  : r0.size;
        off     = s_addr[1:0];
        legal   = (s_addr < AW'(MEM_BYTES));
        case (s_size)
            2'd0:    legal = legal;
            2'd1:    legal = legal && !off[0];
            2'd2:    legal = legal && (off == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Memory drive: idle bus is all zero; illegal accesses never write.
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_we    = '0;
        if (any_gnt) begin
            m_addr = s_addr;
            if (legal) begin
                case (s_size)
                    2'd0: begin
                        m_wdata = {4{s_wdata[7:0]}};
                        m_we    = 4'b0001 << off;
                    end
                    2'd1: begin
                        m_wdata = {2{s_wdata[15:0]}};
                        m_we    = off[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        m_wdata = s_wdata;
                        m_we    = 4'b1111;
                    end
                endcase
                if (!s_wr) begin
                    m_we = '0;
                end
            end
        end
    end

    // Load extraction: right-align the addressed lanes and zero-extend.
    always_comb begin
        ld_shift = m_rdata >> {off, 3'b000};
        case (s_size)
            2'd0:    ld_data = {24'b0, ld_shift[7:0]};
            2'd1:    ld_data = {16'b0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = gnt0 && !legal;
        err1_d    = gnt1 && !legal;
        rdata0_d  = (gnt0 && legal && !s_wr) ? ld_data : '0;
        rdata1_d  = (gnt1 && legal && !s_wr) ? ld_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign r0.gnt    = gnt0;
    assign r1.gnt    = gnt1;
    assign r0.rvalid = rvalid0_q;
    assign r1.rvalid = rvalid1_q;
    assign r0.err    = err0_q;
    assign r1.err    = err1_q;
    assign r0.rdata  = rdata0_q;
    assign r1.rdata  = rdata1_q;

    logic unused_lw;
    assign unused_lw = (LW == 4);
endmodule
